branch_cmp_pipe: RTL

Parametrised, pipelined branch comparator for the core's execute path. Evaluates the RISC-V branch condition selected by `cmp_op` on two XLEN-bit operands. Carries the result, a caller tag and an illegal-op flag through `STAGES` registered stages with valid/ready flow control and a synchronous flush. Supersedes the single-cycle 32-bit combinational compare unit.

---
 rtl/branch_cmp_pkg.sv | 17 +
 rtl/branch_cmp_core.sv | 38 +++
 rtl/branch_cmp_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the branch comparator: RISC-V funct3 branch codes
// and a legality helper used by the compare core.
package branch_cmp_pkg;

   localparam logic [2:0] CMP_BEQ  = 3'b000;
   localparam logic [2:0] CMP_BNE  = 3'b001;
   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BGE  = 3'b101;
   localparam logic [2:0] CMP_BLTU = 3'b110;
   localparam logic [2:0] CMP_BGEU = 3'b111;

   // 010 and 011 are the only holes in the funct3 branch space
   function automatic logic cmp_op_legal(input logic [2:0] op);
      return op[2:1] != 2'b01;
   endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch condition evaluator. Signed compare uses bit XLEN-1
// as sign; unsigned compare uses the raw operand bits.
module branch_cmp_core
   import branch_cmp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_d,
   input  logic [XLEN-1:0] rs2_d,
   input  logic [2:0]      cmp_op,
   output logic            b,
   output logic            err
);

   logic eq;
   logic lt_s;
   logic lt_u;

   assign eq   = (rs1_d == rs2_d);
   assign lt_s = ($signed(rs1_d) < $signed(rs2_d));
   assign lt_u = (rs1_d < rs2_d);

   // select the condition; illegal codes report err with b forced low
   always_comb begin
      b   = 1'b0;
      err = !cmp_op_legal(cmp_op);
      case (cmp_op)
         CMP_BEQ:  b = eq;
         CMP_BNE:  b = !eq;
         CMP_BLT:  b = lt_s;
         CMP_BGE:  b = !lt_s;
         CMP_BLTU: b = lt_u;
         CMP_BGEU: b = !lt_u;
         default:  b = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator: one compare core ahead of STAGES collapsing
// valid/ready register stages carrying {b, err, tag}, with synchronous flush.
// Optional delivery statistics are built when BRANCH_CMP_PIPE_STATS_EN is
// defined; otherwise the counter ports read 0 and no counter flops exist.
module branch_cmp_pipe
   import branch_cmp_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  rs1_d,
   input  logic [XLEN-1:0]  rs2_d,
   input  logic [2:0]       cmp_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_b,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] total_cnt
);

   logic                          core_b;
   logic                          core_err;
   logic                          accept;
   logic [STAGES-1:0]             vld_pipe;
   logic [STAGES-1:0]             b_pipe;
   logic [STAGES-1:0]             err_pipe;
   logic [STAGES-1:0][TAG_W-1:0]  tag_pipe;
   logic [STAGES-1:0]             adv;

   branch_cmp_core #(.XLEN(XLEN)) u_core (
      .rs1_d  (rs1_d),
      .rs2_d  (rs2_d),
      .cmp_op (cmp_op),
      .b      (core_b),
      .err    (core_err)
   );

   // a full stage moves on when the next stage is empty or itself moving;
   // resolved from the output end backwards so bubbles collapse
   always_comb begin
      adv = '0;
      adv[STAGES-1] = vld_pipe[STAGES-1] && out_ready;
      for (int k = STAGES-2; k >= 0; k--) begin
         adv[k] = vld_pipe[k] && (!vld_pipe[k+1] || adv[k+1]);
      end
   end

   assign in_ready = !flush && (!vld_pipe[0] || adv[0]);
   assign accept   = in_valid && in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             ld;
      logic             b_in;
      logic             err_in;
      logic [TAG_W-1:0] tag_in;
      logic             vld_q;
      logic             b_q;
      logic             err_q;
      logic [TAG_W-1:0] tag_q;

      if (k == 0) begin : g_head
         assign ld     = accept;
         assign b_in   = core_b;
         assign err_in = core_err;
         assign tag_in = in_tag;
      end else begin : g_body
         assign ld     = adv[k-1];
         assign b_in   = b_pipe[k-1];
         assign err_in = err_pipe[k-1];
         assign tag_in = tag_pipe[k-1];
      end

      // stage register: flush kills the valid bit, payload only moves on load
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            b_q   <= 1'b0;
            err_q <= 1'b0;
            tag_q <= '0;
         end else begin
            if (flush)        vld_q <= 1'b0;
            else if (ld)      vld_q <= 1'b1;
            else if (adv[k])  vld_q <= 1'b0;
            if (ld) begin
               b_q   <= b_in;
               err_q <= err_in;
               tag_q <= tag_in;
            end
         end
      end

      assign vld_pipe[k] = vld_q;
      assign b_pipe[k]   = b_q;
      assign err_pipe[k] = err_q;
      assign tag_pipe[k] = tag_q;
   end

   assign out_valid = vld_pipe[STAGES-1];
   assign out_b     = b_pipe[STAGES-1];
   assign out_err   = err_pipe[STAGES-1];
   assign out_tag   = tag_pipe[STAGES-1];

`ifdef BRANCH_CMP_PIPE_STATS_EN
   logic             xfer;
   logic [CNT_W-1:0] taken_q;
   logic [CNT_W-1:0] total_q;

   assign xfer = out_valid && out_ready;

   // saturating delivery counters; a transfer in a flush cycle still counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q <= '0;
         total_q <= '0;
      end else if (xfer) begin
         if (total_q != '1)            total_q <= total_q + 1'b1;
         if (out_b && taken_q != '1)   taken_q <= taken_q + 1'b1;
      end
   end

   assign taken_cnt = taken_q;
   assign total_cnt = total_q;
`else
   assign taken_cnt = '0;
   assign total_cnt = '0;
`endif

endmodule
